jtag_shift_engine: RTL and testbench

Synthesizable JTAG master that replaces per-pin TCK/TMS/TDI toggling with whole-scan commands. Each accepted command is executed as a complete TAP-reset, IR-scan or DR-scan sequence on the JTAG pins, and the TDO bits are returned in one response beat. The block sits between a test sequencer (simulation harness or on-chip boot/debug controller) and the SoC top's `jtag_tck_i`/`jtag_tms_i`/`jtag_tdi_i`/`jtag_trst_ni`/`jtag_tdo_o` pins. It is parametrised in scan width and TCK rate.

---
 rtl/jtag_shift_engine.sv | 214 +++++++++++++++++++++
 tb/tb_jtag_shift_engine.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_engine.sv
// ---------------------------------------------------------------------------
// jtag_shift_engine
//
// Command-level JTAG master. Each accepted command is played out on the
// JTAG pins as one whole sequence (TAP reset, IR scan or DR scan), starting
// and ending in Run-Test/Idle. The TDO bits seen during the shift phase come
// back as a single response beat.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_type              0 TAP reset, 1 IR scan, 2 DR scan, 3 reserved
//   cmd_len               scan length in bits (ignored for TAP reset)
//   cmd_data              TDI bits, LSB shifted first
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              captured TDO bits, right-aligned, bit0 first
//   rsp_err               command was rejected, no pin activity
//   jtag_tck_o/tms_o/tdi_o, jtag_trst_no, jtag_tdo_i   JTAG pins
// ---------------------------------------------------------------------------
module jtag_shift_engine #(
   parameter int DATA_W  = 32,
   parameter int CLK_DIV = 4,
   parameter int LEN_W   = $clog2(DATA_W + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_type,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              jtag_tck_o,
   output logic              jtag_tms_o,
   output logic              jtag_tdi_o,
   output logic              jtag_trst_no,
   input  logic              jtag_tdo_i
);

   // Step index needs to hold DATA_W+5 plus an all-ones "before step 0" value.
   localparam int SW = $clog2(DATA_W + 8);
   localparam int DW = $clog2(2 * CLK_DIV);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] T_RST = 2'd0;
   localparam logic [1:0] T_IR  = 2'd1;

   logic [1:0]        r_state;
   logic              r_ready;
   logic [1:0]        r_type;
   logic [LEN_W-1:0]  r_len;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_cap;
   logic [DATA_W-1:0] r_rspData;
   logic              r_rspErr;
   logic              r_errPend;
   logic [SW-1:0]     r_step;
   logic [DW-1:0]     r_div;
   logic              r_tck;
   logic              r_tms;
   logic              r_tdi;
   logic              r_trstN;

   logic              w_accept;
   logic              w_cmdErr;
   logic              w_isScan;
   logic [SW-1:0]     w_pre;
   logic [SW-1:0]     w_shiftEnd;
   logic [SW-1:0]     w_lastStep;
   logic [SW-1:0]     w_nextStep;
   logic              w_curShift;
   logic              w_nextShift;
   logic              w_nextTms;
   logic              w_rise;
   logic              w_fall;
   logic [LEN_W-1:0]  w_align;

   assign w_accept = cmd_valid & r_ready;
   assign w_cmdErr = (cmd_type == 2'd3) ||
                     ((cmd_type != T_RST) &&
                      ((cmd_len == '0) || (cmd_len > LEN_W'(DATA_W))));

   // Step layout of a scan: w_pre lead-in steps walk the TAP into Shift-xR,
   // steps [w_pre, w_shiftEnd) are the shift steps, then two exit steps
   // (Update-xR, Run-Test/Idle). A TAP reset is always steps 0..5.
   assign w_isScan    = (r_type != T_RST);
   assign w_pre       = (r_type == T_IR) ? SW'(4) : SW'(3);
   assign w_shiftEnd  = w_pre + SW'(r_len);
   assign w_lastStep  = w_isScan ? (w_shiftEnd + SW'(1)) : SW'(5);
   assign w_nextStep  = r_step + SW'(1);
   assign w_curShift  = w_isScan && (r_step >= w_pre) && (r_step < w_shiftEnd);
   assign w_nextShift = w_isScan && (w_nextStep >= w_pre) && (w_nextStep < w_shiftEnd);
   assign w_rise      = (r_div == DW'(CLK_DIV - 1));
   assign w_fall      = (r_div == DW'(2 * CLK_DIV - 1));

   // The captured bits enter at the MSB, so the first bit ends up at
   // DATA_W-L and needs this much right shift to land on bit 0.
   assign w_align = LEN_W'(DATA_W) - r_len;

   // TMS value for the step about to begin.
   always_comb begin
      w_nextTms = 1'b0;
      if (!w_isScan) begin
         w_nextTms = (w_nextStep < SW'(5));
      end else if (w_nextStep < w_pre) begin
         w_nextTms = (r_type == T_IR) ? (w_nextStep < SW'(2)) : (w_nextStep < SW'(1));
      end else if (w_nextShift) begin
         w_nextTms = (w_nextStep == (w_shiftEnd - SW'(1)));
      end else begin
         w_nextTms = (w_nextStep == w_shiftEnd);
      end
   end

   // Main controller. On accept the step counter is parked at all-ones with
   // the divider at its last count, so the very next edge behaves like a
   // TCK-fall and loads step 0. That setup cycle gives every command,
   // including a rejected one, a uniform first-edge latency; a rejected
   // command uses it to jump straight to the response without touching pins.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b0;
         r_type    <= T_RST;
         r_len     <= '0;
         r_data    <= '0;
         r_cap     <= '0;
         r_rspData <= '0;
         r_rspErr  <= 1'b0;
         r_errPend <= 1'b0;
         r_step    <= '0;
         r_div     <= '0;
         r_tck     <= 1'b0;
         r_tms     <= 1'b1;
         r_tdi     <= 1'b0;
         r_trstN   <= 1'b0;
      end else begin
         r_trstN <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_ready   <= 1'b0;
                  r_type    <= cmd_type;
                  r_len     <= cmd_len;
                  r_data    <= cmd_data;
                  r_cap     <= '0;
                  r_errPend <= w_cmdErr;
                  r_step    <= '1;
                  r_div     <= DW'(2 * CLK_DIV - 1);
                  r_state   <= S_RUN;
               end
            end
            S_RUN: begin
               r_div <= r_div + DW'(1);
               if (w_rise) begin
                  r_tck <= 1'b1;
                  if (w_curShift) begin
                     r_cap <= {jtag_tdo_i, r_cap[DATA_W-1:1]};
                  end
               end
               if (w_fall) begin
                  r_tck <= 1'b0;
                  r_div <= '0;
                  if (r_errPend) begin
                     r_state   <= S_RESP;
                     r_rspErr  <= 1'b1;
                     r_rspData <= '0;
                  end else if (r_step == w_lastStep) begin
                     r_state   <= S_RESP;
                     r_tdi     <= 1'b0;
                     r_rspErr  <= 1'b0;
                     r_rspData <= r_cap >> w_align;
                  end else begin
                     r_step <= w_nextStep;
                     r_tms  <= w_nextTms;
                     if (w_nextShift) begin
                        r_tdi  <= r_data[0];
                        r_data <= r_data >> 1;
                     end else begin
                        r_tdi <= 1'b0;
                     end
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready    = r_ready;
   assign rsp_valid    = (r_state == S_RESP);
   assign rsp_data     = r_rspData;
   assign rsp_err      = r_rspErr;
   assign jtag_tck_o   = r_tck;
   assign jtag_tms_o   = r_tms;
   assign jtag_tdi_o   = r_tdi;
   assign jtag_trst_no = r_trstN;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_jtag_shift_engine
//
// Bench for jtag_shift_engine with DATA_W=32, CLK_DIV=2. A behavioural TAP
// (IDCODE 32'h04F5484D, 5-bit IR) hangs off the JTAG pins; a one-bit
// TCK-rise loopback flop can replace its TDO. Expected responses go into a
// scoreboard queue as each command is driven and are popped when the engine
// presents its response.
// ---------------------------------------------------------------------------
module tb_jtag_shift_engine;

   localparam int DATA_W  = 32;
   localparam int CLK_DIV = 2;
   localparam int LEN_W   = $clog2(DATA_W + 1);
   localparam logic [31:0] IDCODE = 32'h04F5484D;
   localparam logic [4:0]  IR_CAPTURE = 5'b00101;

   typedef enum logic [3:0] {
      TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR, UPDR,
      SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPIR
   } tapStateT;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } expT;

   logic              clock = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_type;
   logic [LEN_W-1:0]  cmd_len;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;
   logic              jtag_tck_o;
   logic              jtag_tms_o;
   logic              jtag_tdi_o;
   logic              jtag_trst_no;
   logic              jtag_tdo_i;

   tapStateT    tapState;
   logic [4:0]  tapIr;
   logic [4:0]  tapIrSh;
   logic [31:0] tapDr;
   logic        tapTdo = 1'b0;
   logic        loopFlop = 1'b0;
   logic        loopMode = 1'b0;

   int          riseCount = 0;
   logic [63:0] tmsHist = '0;
   int          checkCount = 0;
   int          errorCount = 0;
   expT         sbQ[$];

   jtag_shift_engine #(
      .DATA_W (DATA_W),
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_type    (cmd_type),
      .cmd_len     (cmd_len),
      .cmd_data    (cmd_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .jtag_tck_o  (jtag_tck_o),
      .jtag_tms_o  (jtag_tms_o),
      .jtag_tdi_o  (jtag_tdi_o),
      .jtag_trst_no(jtag_trst_no),
      .jtag_tdo_i  (jtag_tdo_i)
   );

   // System clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Count TCK rises and keep a history of TMS seen at each one.
   always @(posedge jtag_tck_o) begin
      riseCount = riseCount + 1;
      tmsHist   = {tmsHist[62:0], jtag_tms_o};
   end

   function automatic tapStateT tapNext(input tapStateT s, input logic tms);
      case (s)
         TLR:     return tms ? TLR     : RTI;
         RTI:     return tms ? SELDR   : RTI;
         SELDR:   return tms ? SELIR   : CAPDR;
         CAPDR:   return tms ? EX1DR   : SHDR;
         SHDR:    return tms ? EX1DR   : SHDR;
         EX1DR:   return tms ? UPDR    : PAUSEDR;
         PAUSEDR: return tms ? EX2DR   : PAUSEDR;
         EX2DR:   return tms ? UPDR    : SHDR;
         UPDR:    return tms ? SELDR   : RTI;
         SELIR:   return tms ? TLR     : CAPIR;
         CAPIR:   return tms ? EX1IR   : SHIR;
         SHIR:    return tms ? EX1IR   : SHIR;
         EX1IR:   return tms ? UPIR    : PAUSEIR;
         PAUSEIR: return tms ? EX2IR   : PAUSEIR;
         EX2IR:   return tms ? UPIR    : SHIR;
         default: return tms ? SELDR   : RTI;
      endcase
   endfunction

   // Behavioural TAP: IR=1 selects IDCODE, anything else selects BYPASS.
   always @(posedge jtag_tck_o or negedge jtag_trst_no) begin
      if (!jtag_trst_no) begin
         tapState <= TLR;
         tapIr    <= 5'd1;
      end else begin
         case (tapState)
            TLR:   tapIr   <= 5'd1;
            CAPDR: tapDr   <= (tapIr == 5'd1) ? IDCODE : 32'h0;
            SHDR:  tapDr   <= (tapIr == 5'd1) ? {jtag_tdi_o, tapDr[31:1]} : {31'h0, jtag_tdi_o};
            CAPIR: tapIrSh <= IR_CAPTURE;
            SHIR:  tapIrSh <= {jtag_tdi_o, tapIrSh[4:1]};
            UPIR:  tapIr   <= tapIrSh;
            default: ;
         endcase
         tapState <= tapNext(tapState, jtag_tms_o);
      end
   end

   // TAP output changes on the falling TCK edge.
   always @(negedge jtag_tck_o) begin
      tapTdo <= (tapState == SHDR) ? tapDr[0] : ((tapState == SHIR) ? tapIrSh[0] : 1'b0);
   end

   // Loopback path: TDI registered on TCK rise, fed back as TDO.
   always @(posedge jtag_tck_o) begin
      loopFlop <= jtag_tdi_o;
   end

   assign jtag_tdo_i = loopMode ? loopFlop : tapTdo;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount = checkCount + 1;
      if (observed !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pop the oldest expected response and compare against what is presented.
   task automatic collectResponse(input string tag);
      expT e;
      if (sbQ.size() == 0) begin
         checkOutput({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
         e = sbQ.pop_front();
         checkOutput({tag, "_data"}, rsp_data, e.data);
         checkOutput({tag, "_err"}, rsp_err, e.err);
      end
   endtask

   // Drive one command, measure response latency and TCK rises, optionally
   // hold off rsp_ready, then compare and complete the handshake.
   task automatic applyStimulus(input logic [1:0] t, input logic [LEN_W-1:0] len,
                                input logic [31:0] data, input logic [31:0] expData,
                                input logic expErr, input int expCycle,
                                input int expRises, input int hold, input string tag);
      int w;
      int n;
      int r0;
      expT e;
      e.data = expData;
      e.err  = expErr;
      sbQ.push_back(e);
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(posedge clock);
         #1;
         w++;
      end
      checkOutput({tag, "_ready"}, cmd_ready, 1);
      r0        = riseCount;
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_len   = len;
      cmd_data  = data;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom_range(0, 3));
      cmd_len   = LEN_W'($urandom_range(0, 63));
      cmd_data  = $urandom;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!rsp_valid && n < 2000);
      checkOutput({tag, "_cycle"}, n, expCycle);
      checkOutput({tag, "_rises"}, riseCount - r0, expRises);
      if (hold > 0) begin
         repeat (hold) @(posedge clock);
         #1;
         checkOutput({tag, "_hold_valid"}, rsp_valid, 1);
      end
      collectResponse(tag);
      rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
   endtask

   // Absolute time bound so the run cannot hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r0;
      int w;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_type  = '0;
      cmd_len   = '0;
      cmd_data  = '0;
      rsp_ready = 1'b0;

      // Reset values.
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_ready", cmd_ready, 0);
      checkOutput("rst_tck", jtag_tck_o, 0);
      checkOutput("rst_tms", jtag_tms_o, 1);
      checkOutput("rst_tdi", jtag_tdi_o, 0);
      checkOutput("rst_trst", jtag_trst_no, 0);
      checkOutput("rst_valid", rsp_valid, 0);
      checkOutput("rst_data", rsp_data, 0);
      checkOutput("rst_err", rsp_err, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("post_rst_ready", cmd_ready, 1);
      checkOutput("post_rst_trst", jtag_trst_no, 1);
      r0 = riseCount;
      repeat (50) @(posedge clock);
      #1;
      checkOutput("idle_rises", riseCount - r0, 0);
      checkOutput("idle_tck", jtag_tck_o, 0);

      // TAP reset: 6 steps.
      applyStimulus(2'd0, '0, 32'h0, 32'h0, 1'b0, 25, 6, 0, "tap_reset");
      checkOutput("tap_reset_tms_seq", tmsHist[5:0], 6'b111110);
      checkOutput("tap_reset_state", tapState, RTI);
      checkOutput("idle_after_tck", jtag_tck_o, 0);
      checkOutput("idle_after_tms", jtag_tms_o, 0);

      // IR scan selects IDCODE, then a 32-bit DR scan reads it.
      applyStimulus(2'd1, 6'd5, 32'h01, {27'h0, IR_CAPTURE}, 1'b0, 45, 11, 0, "ir_scan");
      checkOutput("ir_value", tapIr, 5'd1);
      applyStimulus(2'd2, 6'd32, 32'h0, IDCODE, 1'b0, 149, 37, 0, "dr_idcode");
      checkOutput("dr_state", tapState, RTI);

      // Loopback: captured data is TDI delayed by one shift step.
      loopMode = 1'b1;
      applyStimulus(2'd2, 6'd8, 32'hA5, 32'h4A, 1'b0, 53, 13, 0, "loop_dr8");
      loopMode = 1'b0;

      // Rejected commands: one-cycle response, no TCK activity.
      applyStimulus(2'd2, 6'd0, 32'hFFFF, 32'h0, 1'b1, 1, 0, 10, "err_len0");
      applyStimulus(2'd1, 6'd33, 32'h1234, 32'h0, 1'b1, 1, 0, 0, "err_len33");
      applyStimulus(2'd3, 6'd8, 32'h55, 32'h0, 1'b1, 1, 0, 0, "err_type3");

      // Reset during step 10 of a 37-step DR scan drops the command.
      w = 0;
      while (!cmd_ready && w < 100) begin
         @(posedge clock);
         #1;
         w++;
      end
      cmd_valid = 1'b1;
      cmd_type  = 2'd2;
      cmd_len   = 6'd32;
      cmd_data  = 32'hDEADBEEF;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      repeat (42) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("midrst_tck", jtag_tck_o, 0);
      checkOutput("midrst_tms", jtag_tms_o, 1);
      checkOutput("midrst_tdi", jtag_tdi_o, 0);
      checkOutput("midrst_valid", rsp_valid, 0);
      checkOutput("midrst_trst", jtag_trst_no, 0);
      checkOutput("midrst_ready", cmd_ready, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("midrst_trst_release", jtag_trst_no, 1);
      checkOutput("midrst_no_rsp", rsp_valid, 0);

      applyStimulus(2'd0, '0, 32'h0, 32'h0, 1'b0, 25, 6, 0, "tap_reset2");
      applyStimulus(2'd2, 6'd32, 32'h0, IDCODE, 1'b0, 149, 37, 0, "dr_idcode2");

      checkOutput("sb_empty", sbQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
